// File: rtl/arp_pkg.sv
// ARP frame constants, byte offsets, receiver state encoding and helper
// functions. Shared by the ARP receive and transmit paths.
package arp_pkg;

  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IP  = 16'h0800;
  localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
  localparam logic [15:0] ARP_OP_REPLY  = 16'h0002;
  localparam logic [7:0]  ARP_HLEN      = 8'h06;
  localparam logic [7:0]  ARP_PLEN      = 8'h04;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hd5;

  // Byte offsets counted from the first byte after the SFD.
  localparam logic [5:0] OFF_DMAC  = 6'd0;
  localparam logic [5:0] OFF_TYPE  = 6'd12;
  localparam logic [5:0] OFF_HTYPE = 6'd14;
  localparam logic [5:0] OFF_PTYPE = 6'd16;
  localparam logic [5:0] OFF_HLEN  = 6'd18;
  localparam logic [5:0] OFF_PLEN  = 6'd19;
  localparam logic [5:0] OFF_OP    = 6'd20;
  localparam logic [5:0] OFF_SMAC  = 6'd22;
  localparam logic [5:0] OFF_SIP   = 6'd28;
  localparam logic [5:0] OFF_TIP   = 6'd38;
  localparam logic [5:0] OFF_FCS   = 6'd60;
  localparam logic [5:0] OFF_LAST  = 6'd63;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_FRAME,
    ST_FCS,
    ST_CHECK,
    ST_DROP
  } arp_state_t;

  // Peer information reported once a frame is accepted.
  typedef struct packed {
    logic        op;   // 1 = request, 0 = reply
    logic [47:0] mac;
    logic [31:0] ip;
  } arp_peer_t;

  // Byte idx of a 48-bit value, MSB first (idx 0 = bits 47:40).
  function automatic logic [7:0] be_byte48(input logic [47:0] v, input logic [5:0] idx);
    logic [47:0] s;
    s = v << {idx, 3'b000};
    return s[47:40];
  endfunction

  // Byte idx of a 32-bit value, MSB first (idx 0 = bits 31:24).
  function automatic logic [7:0] be_byte32(input logic [31:0] v, input logic [5:0] idx);
    logic [31:0] s;
    s = v << {idx, 3'b000};
    return s[31:24];
  endfunction

endpackage

// File: rtl/arp_rx.sv
// Byte-wide ARP receiver.
// Strips preamble/SFD, filters on destination MAC (local or broadcast),
// EtherType, ARP header fields and target IP, streams frame bytes 0..59
// into the external CRC32 engine and compares its result with the received
// FCS. On a good frame the sender MAC/IP and opcode are published.
// Ports:
//   arp_rx_clk, rst         clock, synchronous active-high reset
//   arp_rx_data/valid       received byte stream (valid = rx_dv)
//   crc_data                result of the external CRC32 engine
//   crc_en/init/din         feed to the external CRC32 engine (registered)
//   arp_rx_done/err         one-cycle result pulses
//   arp_rx_op, src_mac/ip   peer info from the last accepted frame
module arp_rx
  import arp_pkg::*;
#(
  parameter logic [47:0] FPGA_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] FPGA_IP  = 32'hc0_a8_00_03
) (
  input  logic        arp_rx_clk,
  input  logic        rst,
  input  logic [7:0]  arp_rx_data,
  input  logic        arp_rx_valid,
  input  logic [31:0] crc_data,
  output logic        crc_en,
  output logic        crc_init,
  output logic [7:0]  crc_din,
  output logic        arp_rx_done,
  output logic        arp_rx_err,
  output logic        arp_rx_op,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip
);

  arp_state_t  state, state_nxt;
  logic [5:0]  cnt_byte;
  logic [31:0] fcs_rx;
  arp_peer_t   shadow;

  // Destination MAC must match local or broadcast as a whole, so the two
  // candidates are tracked separately across bytes 0..5.
  logic        lcl_q, bc_q;
  logic        lcl_run, bc_run;
  logic        field_ok;

  wire [7:0] d = arp_rx_data;

  always_comb begin
    field_ok = 1'b1;
    lcl_run  = 1'b0;
    bc_run   = 1'b0;
    if (cnt_byte < OFF_DMAC + 6'd6) begin
      lcl_run  = (cnt_byte == OFF_DMAC || lcl_q) &&
                 (d == be_byte48(FPGA_MAC, cnt_byte - OFF_DMAC));
      bc_run   = (cnt_byte == OFF_DMAC || bc_q) && (d == 8'hff);
      field_ok = lcl_run || bc_run;
    end else if (cnt_byte == OFF_TYPE) begin
      field_ok = (d == ETH_TYPE_ARP[15:8]);
    end else if (cnt_byte == OFF_TYPE + 6'd1) begin
      field_ok = (d == ETH_TYPE_ARP[7:0]);
    end else if (cnt_byte == OFF_HTYPE) begin
      field_ok = (d == ARP_HTYPE_ETH[15:8]);
    end else if (cnt_byte == OFF_HTYPE + 6'd1) begin
      field_ok = (d == ARP_HTYPE_ETH[7:0]);
    end else if (cnt_byte == OFF_PTYPE) begin
      field_ok = (d == ARP_PTYPE_IP[15:8]);
    end else if (cnt_byte == OFF_PTYPE + 6'd1) begin
      field_ok = (d == ARP_PTYPE_IP[7:0]);
    end else if (cnt_byte == OFF_HLEN) begin
      field_ok = (d == ARP_HLEN);
    end else if (cnt_byte == OFF_PLEN) begin
      field_ok = (d == ARP_PLEN);
    end else if (cnt_byte == OFF_OP) begin
      field_ok = (d == ARP_OP_REQ[15:8]);
    end else if (cnt_byte == OFF_OP + 6'd1) begin
      field_ok = (d == ARP_OP_REQ[7:0]) || (d == ARP_OP_REPLY[7:0]);
    end else if (cnt_byte >= OFF_TIP && cnt_byte < OFF_TIP + 6'd4) begin
      field_ok = (d == be_byte32(FPGA_IP, cnt_byte - OFF_TIP));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (arp_rx_valid && d == PREAMBLE_BYTE) state_nxt = ST_PREAMBLE;
      ST_PREAMBLE:
        if (!arp_rx_valid)           state_nxt = ST_IDLE;
        else if (d == SFD_BYTE)      state_nxt = ST_FRAME;
        else if (d != PREAMBLE_BYTE) state_nxt = ST_DROP;
      ST_FRAME:
        if (!arp_rx_valid)                       state_nxt = ST_IDLE;
        else if (!field_ok)                      state_nxt = ST_DROP;
        else if (cnt_byte == OFF_FCS - 6'd1)     state_nxt = ST_FCS;
      ST_FCS:
        if (!arp_rx_valid)                       state_nxt = ST_IDLE;
        else if (cnt_byte == OFF_LAST)           state_nxt = ST_CHECK;
      // Trailing bytes are flushed through DROP; if the frame already
      // ended, go straight to IDLE so a one-cycle gap is enough.
      ST_CHECK:
        state_nxt = arp_rx_valid ? ST_DROP : ST_IDLE;
      ST_DROP:
        if (!arp_rx_valid) state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge arp_rx_clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt_byte    <= '0;
      fcs_rx      <= '0;
      shadow      <= '0;
      lcl_q       <= 1'b0;
      bc_q        <= 1'b0;
      crc_en      <= 1'b0;
      crc_init    <= 1'b1;
      crc_din     <= '0;
      arp_rx_done <= 1'b0;
      arp_rx_err  <= 1'b0;
      arp_rx_op   <= 1'b0;
      src_mac     <= '0;
      src_ip      <= '0;
    end else begin
      state       <= state_nxt;
      crc_en      <= 1'b0;
      arp_rx_done <= 1'b0;
      arp_rx_err  <= 1'b0;
      crc_init    <= (state_nxt == ST_IDLE) || (state_nxt == ST_PREAMBLE);

      if (state == ST_IDLE || state == ST_PREAMBLE) cnt_byte <= '0;

      if ((state == ST_FRAME || state == ST_FCS) && arp_rx_valid)
        cnt_byte <= cnt_byte + 6'd1;

      if (state == ST_FRAME && arp_rx_valid) begin
        crc_en  <= 1'b1;
        crc_din <= d;
        if (cnt_byte < OFF_DMAC + 6'd6) begin
          lcl_q <= lcl_run;
          bc_q  <= bc_run;
        end
        if (cnt_byte == OFF_OP + 6'd1)
          shadow.op <= (d == ARP_OP_REQ[7:0]);
        if (cnt_byte >= OFF_SMAC && cnt_byte < OFF_SMAC + 6'd6)
          shadow.mac <= {shadow.mac[39:0], d};
        if (cnt_byte >= OFF_SIP && cnt_byte < OFF_SIP + 6'd4)
          shadow.ip <= {shadow.ip[23:0], d};
      end

      // First FCS byte ends up in [7:0], matching the engine's byte order.
      if (state == ST_FCS && arp_rx_valid)
        fcs_rx <= {d, fcs_rx[31:8]};

      if (state == ST_CHECK) begin
        if (crc_data == fcs_rx) begin
          arp_rx_done <= 1'b1;
          arp_rx_op   <= shadow.op;
          src_mac     <= shadow.mac;
          src_ip      <= shadow.ip;
        end else begin
          arp_rx_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_arp_rx.sv
module tb_arp_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  data = 8'h00;
  logic        valid = 1'b0;
  logic [31:0] crc_data;
  logic        crc_en, crc_init, done, err, op;
  logic [7:0]  crc_din;
  logic [47:0] src_mac;
  logic [31:0] src_ip;

  arp_rx dut (
    .arp_rx_clk(clk), .rst(rst), .arp_rx_data(data), .arp_rx_valid(valid),
    .crc_data(crc_data), .crc_en(crc_en), .crc_init(crc_init), .crc_din(crc_din),
    .arp_rx_done(done), .arp_rx_err(err), .arp_rx_op(op),
    .src_mac(src_mac), .src_ip(src_ip)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Standard Ethernet CRC32 (reflected), standing in for the shared engine.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++)
      r = (r[0] ^ b[k]) ? ((r >> 1) ^ 32'hedb88320) : (r >> 1);
    return r;
  endfunction

  logic [31:0] creg;
  always @(posedge clk)
    if (crc_init) creg <= 32'hffffffff;
    else if (crc_en) creg <= crc_upd(creg, crc_din);
  assign crc_data = ~creg;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  logic [47:0] my_mac = 48'h001122334455;
  logic [31:0] my_ip  = 32'hc0a80003;

  // Expectations keyed by the cycle in which the output must be visible.
  bit          exp_done[int];
  bit          exp_err[int];
  logic [7:0]  exp_crc[int];
  bit          crc_dc[int];
  bit          rst_at[int];
  logic [80:0] done_val[int];
  logic [80:0] mdl = '0;
  bit          chk_on = 1'b0;
  int          ndone = 0, nerr = 0;

  always @(negedge clk) begin
    if (done === 1'b1) ndone++;
    if (err === 1'b1) nerr++;
    if (chk_on) begin
      if (rst_at.exists(cyc)) begin
        mdl = '0;
        chk("init_after_rst", 64'(crc_init), 64'd1);
      end
      if (exp_done.exists(cyc)) mdl = done_val[cyc];
      chk("done", 64'(done), 64'(exp_done.exists(cyc)));
      chk("err", 64'(err), 64'(exp_err.exists(cyc)));
      if (!crc_dc.exists(cyc)) begin
        chk("crc_en", 64'(crc_en), 64'(exp_crc.exists(cyc)));
        if (exp_crc.exists(cyc)) chk("crc_din", 64'(crc_din), 64'(exp_crc[cyc]));
      end
      chk("op", 64'(op), 64'(mdl[80]));
      chk("src_mac", 64'(src_mac), 64'(mdl[79:32]));
      chk("src_ip", 64'(src_ip), 64'(mdl[31:0]));
    end
  end

  logic [7:0] fr [0:67];
  int         flen;

  task automatic build(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] opc,
                       input logic [47:0] sm, input logic [31:0] si, input logic [31:0] ti,
                       input bit bad, input int extra);
    logic [31:0] c;
    for (int i = 0; i < 6; i++) fr[i] = dst[47-8*i -: 8];
    for (int i = 6; i < 12; i++) fr[i] = 8'($urandom);
    fr[12] = et[15:8]; fr[13] = et[7:0];
    fr[14] = 8'h00; fr[15] = 8'h01; fr[16] = 8'h08; fr[17] = 8'h00;
    fr[18] = 8'h06; fr[19] = 8'h04; fr[20] = opc[15:8]; fr[21] = opc[7:0];
    for (int i = 0; i < 6; i++) fr[22+i] = sm[47-8*i -: 8];
    for (int i = 0; i < 4; i++) fr[28+i] = si[31-8*i -: 8];
    for (int i = 32; i < 38; i++) fr[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) fr[38+i] = ti[31-8*i -: 8];
    for (int i = 42; i < 60; i++) fr[i] = 8'($urandom);
    c = 32'hffffffff;
    for (int i = 0; i < 60; i++) c = crc_upd(c, fr[i]);
    c = ~c;
    fr[60] = c[7:0]; fr[61] = c[15:8]; fr[62] = c[23:16]; fr[63] = c[31:24];
    if (bad) fr[63] = fr[63] ^ 8'hff;
    flen = 64 + extra;
    for (int i = 64; i < flen; i++) fr[i] = 8'($urandom);
  endtask

  // Index of the first byte that breaks the acceptance rules, or -1.
  function automatic int first_fail();
    logic [7:0] hdr [0:7];
    bit lok, bok;
    hdr = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04};
    lok = 1; bok = 1;
    for (int i = 0; i < 6; i++) begin
      lok = lok && (fr[i] == my_mac[47-8*i -: 8]);
      bok = bok && (fr[i] == 8'hff);
      if (!(lok || bok)) return i;
    end
    for (int i = 12; i < 20; i++) if (fr[i] != hdr[i-12]) return i;
    if (fr[20] != 8'h00) return 20;
    if (fr[21] != 8'h01 && fr[21] != 8'h02) return 21;
    for (int i = 38; i < 42; i++) if (fr[i] != my_ip[31-8*(i-38) -: 8]) return i;
    return -1;
  endfunction

  task automatic drive(input logic [7:0] b, input logic v, input logic r);
    @(posedge clk); #1;
    data = b; valid = v; rst = r;
  endtask

  task automatic send_frame(input int abort_at, input int rst_i, input int gap);
    int ffi, n;
    logic [31:0] c;
    bit good;
    ffi = first_fail();
    c = 32'hffffffff;
    for (int i = 0; i < 60; i++) c = crc_upd(c, fr[i]);
    c = ~c;
    good = ({fr[63], fr[62], fr[61], fr[60]} == c);
    for (int p = 0; p < 8; p++) drive((p < 7) ? 8'h55 : 8'hd5, 1'b1, 1'b0);
    for (int i = 0; i < flen; i++) begin
      if (i == abort_at) break;
      drive(fr[i], 1'b1, i == rst_i);
      n = cyc;
      if (i == rst_i) rst_at[n+1] = 1;
      else if (rst_i >= 0 && i > rst_i) crc_dc[n+1] = 1;
      else if (i <= 59 && (ffi < 0 || i <= ffi)) exp_crc[n+1] = fr[i];
      if (i == 63 && ffi < 0 && (rst_i < 0 || rst_i > 63)) begin
        if (good) begin
          exp_done[n+2] = 1;
          done_val[n+2] = {fr[21] == 8'h01, fr[22], fr[23], fr[24], fr[25], fr[26], fr[27],
                           fr[28], fr[29], fr[30], fr[31]};
        end else exp_err[n+2] = 1;
      end
    end
    repeat (gap) drive(8'($urandom), 1'b0, 1'b0);
  endtask

  int d0, e0;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_crc_init", 64'(crc_init), 64'd1);
    chk("rst_crc_en", 64'(crc_en), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_src_mac", 64'(src_mac), 64'd0);
    chk("rst_src_ip", 64'(src_ip), 64'd0);
    drive(8'h00, 1'b0, 1'b0);
    chk_on = 1'b1;

    // Request to broadcast
    build(48'hffffffffffff, 16'h0806, 16'h0001, 48'h00e04c680001, 32'hc0a80091,
          32'hc0a80003, 0, 0);
    send_frame(-1, -1, 4);
    chk("t1_ndone", 64'(ndone), 64'd1);
    chk("t1_op", 64'(op), 64'd1);
    chk("t1_mac", 64'(src_mac), 64'h00e04c680001);
    chk("t1_ip", 64'(src_ip), 64'hc0a80091);

    // Reply to local MAC, with trailing bytes
    build(48'h001122334455, 16'h0806, 16'h0002, 48'h0a0b0c0d0e0f, 32'hc0a80101,
          32'hc0a80003, 0, 3);
    send_frame(-1, -1, 1);
    repeat (3) drive(8'h00, 1'b0, 1'b0);
    chk("t2_ndone", 64'(ndone), 64'd2);
    chk("t2_op", 64'(op), 64'd0);
    chk("t2_mac", 64'(src_mac), 64'h0a0b0c0d0e0f);

    // Wrong target IP
    d0 = ndone; e0 = nerr;
    build(48'hffffffffffff, 16'h0806, 16'h0001, 48'h112233445566, 32'hc0a80092,
          32'hc0a80004, 0, 0);
    send_frame(-1, -1, 1);
    repeat (3) drive(8'h00, 1'b0, 1'b0);
    chk("t3_ndone", 64'(ndone), 64'(d0));
    chk("t3_nerr", 64'(nerr), 64'(e0));

    // Bad FCS
    build(48'hffffffffffff, 16'h0806, 16'h0001, 48'h0000000000aa, 32'h01020304,
          32'hc0a80003, 1, 0);
    send_frame(-1, -1, 4);
    chk("t4_nerr", 64'(nerr), 64'(e0 + 1));
    chk("t4_ndone", 64'(ndone), 64'(d0));
    chk("t4_mac", 64'(src_mac), 64'h0a0b0c0d0e0f);
    chk("t4_ip", 64'(src_ip), 64'hc0a80101);

    // Abort at byte 30, then a good frame
    build(48'hffffffffffff, 16'h0806, 16'h0001, 48'h0000000000bb, 32'h05060708,
          32'hc0a80003, 0, 0);
    send_frame(30, -1, 1);
    build(48'h001122334455, 16'h0806, 16'h0001, 48'h0000000000cc, 32'h0a000001,
          32'hc0a80003, 0, 0);
    send_frame(-1, -1, 4);
    chk("t5_ndone", 64'(ndone), 64'(d0 + 1));
    chk("t5_mac", 64'(src_mac), 64'h0000000000cc);

    // Reset at byte 40, then a good frame
    build(48'hffffffffffff, 16'h0806, 16'h0001, 48'h0000000000dd, 32'h0b000001,
          32'hc0a80003, 0, 0);
    send_frame(-1, 40, 2);
    chk("t6_ndone", 64'(ndone), 64'(d0 + 1));
    chk("t6_mac_clr", 64'(src_mac), 64'd0);
    chk("t6_ip_clr", 64'(src_ip), 64'd0);
    build(48'hffffffffffff, 16'h0806, 16'h0002, 48'h0000000000ee, 32'h0c000001,
          32'hc0a80003, 0, 0);
    send_frame(-1, -1, 4);
    chk("t6_ndone2", 64'(ndone), 64'(d0 + 2));
    chk("t6_mac", 64'(src_mac), 64'h0000000000ee);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      int sel, ab;
      logic [47:0] dst;
      logic [15:0] et, opc;
      logic [31:0] ti;
      sel = $urandom_range(0, 19);
      if (sel < 10)      dst = my_mac;
      else if (sel < 17) dst = 48'hffffffffffff;
      else if (sel < 19) dst = {$urandom, 16'($urandom)};
      else               dst = {8'hff, 40'h1122334455};
      et  = ($urandom_range(0, 9) == 0) ? 16'h0800 : 16'h0806;
      sel = $urandom_range(0, 9);
      opc = (sel == 0) ? 16'h0003 : (sel < 5) ? 16'h0001 : 16'h0002;
      ti  = ($urandom_range(0, 6) == 0) ? {$urandom} : my_ip;
      build(dst, et, opc, {$urandom, 16'($urandom)}, $urandom, ti,
            $urandom_range(0, 4) == 0, $urandom_range(0, 3));
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : -1;
      send_frame(ab, -1, $urandom_range(1, 3));
    end

    repeat (6) drive(8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
